aes128_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes128_inv_cipher_iter_if.sv | 28 ++
 rtl/aes_inv_sub_bytes_16.sv | 11 +
 rtl/aes128_inv_cipher_iter.sv | 98 +++++++++
 tb/tb_aes128_inv_cipher_iter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative inverse cipher.
package aes_pkg;

   localparam int NR = 10;

   typedef logic [127:0] state_t;
   typedef logic [3:0]   rnd_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] m;
      p = 8'h00;
      m = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ m;
         m = xtime(m);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] acc;
      p   = gf_mul(x, x);
      acc = p;
      for (int i = 0; i < 6; i++) begin
         p   = gf_mul(p, p);
         acc = gf_mul(acc, p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // Combined S-box: the field inversion is shared, the affine step moves
   // before or after it depending on direction.
   function automatic logic [7:0] sbox_combined(input logic [7:0] b, input logic inv);
      logic [7:0] pre;
      logic [7:0] mid;
      pre = inv ? sbox_inv_affine(b) : b;
      mid = gf_inv(pre);
      return inv ? mid : sbox_affine(mid);
   endfunction

   // Byte (row r, column c) lives at index 4*c + r, byte 0 in the top bits.
   function automatic state_t inv_shift_rows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   // Circulant {0e,0b,0d,09} built from the x2/x4/x8 xtime chain.
   function automatic state_t inv_mix_columns(input state_t s);
      state_t     o;
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = s[127 - 8*(4*c + r) -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
         end
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] =
               (x8[r] ^ x4[r] ^ x2[r]) ^
               (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4]) ^
               (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4]) ^
               (x8[(r+3)%4] ^ a[(r+3)%4]);
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_if.sv
// Block-in / block-out streams plus round-key fetch for the inverse cipher.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the source holds valid and data stable until then, and ready never
// depends on valid.
interface aes128_inv_cipher_iter_if;
   import aes_pkg::*;

   logic       in_valid;
   logic       in_ready;
   state_t     in_data;
   logic       out_valid;
   logic       out_ready;
   state_t     out_data;
   rnd_t       rk_idx;
   state_t     rk_data;
   logic       busy;
   logic [1:0] dbg_state;

   modport master (
      output in_valid, in_data, out_ready, rk_data,
      input  in_ready, out_valid, out_data, rk_idx, busy, dbg_state
   );

   modport slave (
      input  in_valid, in_data, out_ready, rk_data,
      output in_ready, out_valid, out_data, rk_idx, busy, dbg_state
   );
endinterface

// File: rtl/aes_inv_sub_bytes_16.sv
// Sixteen parallel inverse S-boxes over a full 128-bit state.
module aes_inv_sub_bytes_16
   import aes_pkg::*;
(
   input  state_t i_state,
   output state_t o_state
);
   for (genvar g = 0; g < 16; g++) begin : g_sbox
      assign o_state[127 - 8*g -: 8] = sbox_combined(i_state[127 - 8*g -: 8], 1'b1);
   end
endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock.
module aes128_inv_cipher_iter
   import aes_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   aes128_inv_cipher_iter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_e;

   state_e r_state;
   state_e w_next;
   state_t r_st;
   rnd_t   r_rnd;
   state_t w_shifted;
   state_t w_subbed;
   state_t w_t;
   state_t w_mixed;
   logic   w_hs;

   assign w_shifted = inv_shift_rows(r_st);

   aes_inv_sub_bytes_16 u_inv_sub (
      .i_state (w_shifted),
      .o_state (w_subbed)
   );

   assign w_t     = w_subbed ^ bus.rk_data;
   assign w_mixed = inv_mix_columns(w_t);
   assign w_hs    = bus.in_valid & bus.in_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state: the round-0 step is the last one and lands in DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_next = S_ROUND;
         S_ROUND: if (r_rnd == '0) w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: initial AddRoundKey on accept, then one inverse round per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st  <= '0;
         r_rnd <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_st  <= bus.in_data ^ bus.rk_data;
                  r_rnd <= rnd_t'(NR - 1);
               end
            end
            S_ROUND: begin
               if (r_rnd != '0) begin
                  r_st  <= w_mixed;
                  r_rnd <= rnd_t'(r_rnd - 4'd1);
               end else begin
                  r_st  <= w_t;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from FSM state only
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      bus.rk_idx    = rnd_t'(NR);
      case (r_state)
         S_IDLE:  bus.in_ready = 1'b1;
         S_ROUND: begin
            bus.busy   = 1'b1;
            bus.rk_idx = r_rnd;
         end
         S_DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.out_data  = r_st;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Self-checking bench for the iterative AES-128 inverse cipher.
module tb_aes128_inv_cipher_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   aes128_inv_cipher_iter_if bus ();

   aes128_inv_cipher_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // bench key store and forward-cipher reference
   logic [7:0]   sbox_t [0:255];
   logic [127:0] rk_tab [0:1][0:10];
   logic         key_sel = 1'b0;
   assign bus.rk_data = rk_tab[key_sel][bus.rk_idx];

   int n_checks = 0;
   int n_err    = 0;
   logic [127:0] exp_q [$];
   logic [3:0]   rk_log [$];
   logic         ov_q = 1'b0;
   int           ov_rise_cyc = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] tb_xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] m;
      p = 8'h00;
      m = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ m;
         m = tb_xt(m);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // forward S-box: inverse found by exhaustive search, then the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic sel, input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = tb_xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] tb_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 8*(4*c)     -: 8];
         a1 = s[127 - 8*(4*c + 1) -: 8];
         a2 = s[127 - 8*(4*c + 2) -: 8];
         a3 = s[127 - 8*(4*c + 3) -: 8];
         o[127 - 8*(4*c)     -: 8] = tb_xt(a0) ^ (tb_xt(a1) ^ a1) ^ a2 ^ a3;
         o[127 - 8*(4*c + 1) -: 8] = a0 ^ tb_xt(a1) ^ (tb_xt(a2) ^ a2) ^ a3;
         o[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ tb_xt(a2) ^ (tb_xt(a3) ^ a3);
         o[127 - 8*(4*c + 3) -: 8] = (tb_xt(a0) ^ a0) ^ a1 ^ a2 ^ tb_xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] tb_encrypt(input logic [127:0] pt, input logic sel);
      logic [127:0] s;
      logic [127:0] t;
      s = pt ^ rk_tab[sel][0];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[127 - 8*i -: 8] = sbox_t[s[127 - 8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[127 - 8*(4*c + r) -: 8] = t[127 - 8*(4*((c + r) % 4) + r) -: 8];
         if (rd != 10) s = tb_mix(s);
         s = s ^ rk_tab[sel][rd];
      end
      return s;
   endfunction

   // driver tasks
   task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, output int hs_at);
      logic seen;
      seen = 1'b0;
      hs_at = -1;
      bus.in_valid = 1'b1;
      bus.in_data  = ct;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            seen  = 1'b1;
            hs_at = cyc;
            exp_q.push_back(pt);
         end
      end
      check("handshake_seen", 128'(seen), 128'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) ok = 1'b1;
      end
      check(tag, 128'(ok), 128'd1);
      @(posedge clk); #1;
   endtask

   // scoreboard: pop on each accepted output
   always @(negedge clk) begin
      if (rst) begin
         ov_q <= 1'b0;
      end else begin
         ov_q <= bus.out_valid;
         if (bus.out_valid && !ov_q) ov_rise_cyc <= cyc;
         if ((bus.in_valid && bus.in_ready) || (bus.busy && !bus.out_valid))
            rk_log.push_back(bus.rk_idx);
         if (bus.out_valid && bus.out_ready) begin
            check("sb_expected_present", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check("sb_out_data", bus.out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      check("global_timeout", 128'(n_checks < 0), 128'd1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int t1;
      int t2;
      logic seen;
      logic [127:0] key, pt, ct;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      build_sbox();

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_out_data",  bus.out_data,        128'd0);
      check("rst_busy",      128'(bus.busy),      128'd0);
      check("rst_rk_idx",    128'(bus.rk_idx),    128'd10);
      check("rst_dbg_state", 128'(bus.dbg_state), 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

      // C.1 vector: latency and round-key order
      load_key(1'b0, C1_KEY);
      key_sel = 1'b0;
      rk_log.delete();
      send_block(C1_CT, C1_PT, t1);
      wait_drain("c1_done");
      check("c1_latency", 128'(ov_rise_cyc - t1), 128'd11);
      check("c1_rk_count", 128'(rk_log.size()), 128'd11);
      for (int i = 0; i < 11 && i < rk_log.size(); i++)
         check("c1_rk_idx", 128'(rk_log[i]), 128'(10 - i));

      // Appendix B vector
      load_key(1'b0, B_KEY);
      send_block(B_CT, B_PT, t1);
      wait_drain("b_done");

      // backpressure in DONE
      load_key(1'b0, C1_KEY);
      bus.out_ready = 1'b0;
      send_block(C1_CT, C1_PT, t1);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("bp_out_valid_seen", 128'(seen), 128'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("bp_out_valid", 128'(bus.out_valid), 128'd1);
         check("bp_out_data",  bus.out_data,        C1_PT);
         check("bp_in_ready",  128'(bus.in_ready),  128'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      check("bp_release_idle", 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'b010);
      check("bp_drained", 128'(exp_q.size()), 128'd0);

      // reset mid-block at round 4
      send_block(C1_CT, C1_PT, t1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.busy && bus.rk_idx == 4'd5) seen = 1'b1;
      end
      @(posedge clk); #1;
      check("rst_mid_rnd4", 128'(bus.rk_idx), 128'd4);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_mid_busy",      128'(bus.busy),      128'd0);
      check("rst_mid_rk_idx",    128'(bus.rk_idx),    128'd10);
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      check("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
      send_block(C1_CT, C1_PT, t1);
      wait_drain("rst_mid_recover");

      // back-to-back: C.1 then B with out_ready held high
      load_key(1'b0, C1_KEY);
      load_key(1'b1, B_KEY);
      key_sel = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = C1_CT;
      seen = 1'b0;
      t1 = 0;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            seen = 1'b1;
            t1 = cyc;
            exp_q.push_back(C1_PT);
         end
      end
      check("b2b_hs1", 128'(seen), 128'd1);
      @(posedge clk); #1;
      bus.in_data = B_CT;
      seen = 1'b0;
      t2 = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (bus.out_valid) key_sel = 1'b1;
         if (bus.in_ready) begin
            seen = 1'b1;
            t2 = cyc;
            exp_q.push_back(B_PT);
         end
      end
      check("b2b_hs2", 128'(seen), 128'd1);
      check("b2b_interval", 128'(t2 - t1), 128'd12);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_drain("b2b_done");
      key_sel = 1'b0;

      // random regression against the forward-cipher reference
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         load_key(1'b0, key);
         ct = tb_encrypt(pt, 1'b0);
         send_block(ct, pt, t1);
         wait_drain("rand_done");
      end

      check("final_queue_empty", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
